// File: rtl/game_pkg.sv
// Shared types and board geometry for the Connect-4 board writer.
package game_pkg;

  localparam int ROWS  = 6;
  localparam int COLS  = 7;
  localparam int CELLS = ROWS * COLS;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_COL   = 2'b01,
    ERR_FULL  = 2'b10,
    ERR_STATE = 2'b11
  } err_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_CHECK,
    S_WAIT,
    S_CLEAR
  } state_t;

endpackage

// File: rtl/col_height_counter.sv
// Per-column fill counters; each saturates at ROWS so a full column can never wrap.
module col_height_counter #(
  parameter int ROWS = game_pkg::ROWS,
  parameter int COLS = game_pkg::COLS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc_en,
  input  logic [2:0]            inc_col,
  input  logic                  clr,
  output logic [COLS-1:0][2:0]  heights,
  output logic [COLS-1:0]       col_full
);

  localparam logic [2:0] HMAX = 3'(ROWS);

  logic [COLS-1:0][2:0] r_h;

  // Count one piece into the selected column; clear wipes every column.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h <= '0;
    end else if (clr) begin
      r_h <= '0;
    end else if (inc_en && (r_h[inc_col] != HMAX)) begin
      r_h[inc_col] <= r_h[inc_col] + 3'd1;
    end
  end

  // A column is full once its count reaches the row count.
  always_comb begin
    col_full = '0;
    for (int c = 0; c < COLS; c++) begin
      col_full[c] = (r_h[c] == HMAX);
    end
  end

  assign heights = r_h;

endmodule

// File: rtl/board_writer.sv
// Writer side of the Connect-4 board: validates drops, lands pieces,
// hands each new board to the win checker and latches the verdict.
module board_writer #(
  parameter int ROWS = game_pkg::ROWS,
  parameter int COLS = game_pkg::COLS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              move_valid,
  input  logic [2:0]                        move_col,
  input  logic [1:0]                        move_player,
  input  logic                              clear_req,
  input  logic                              win_flag,
  input  logic [1:0]                        winner_id,
  output logic [0:ROWS-1][0:COLS-1][1:0]    board,
  output logic                              check_en,
  output logic                              move_ready,
  output logic                              move_done,
  output logic                              move_err,
  output logic [1:0]                        err_code,
  output logic                              game_over,
  output logic [1:0]                        winner,
  output logic                              draw,
  output logic [COLS-1:0]                   col_full,
  output logic [5:0]                        move_count
);
  import game_pkg::*;

  localparam logic [3:0] COLS_LIM  = 4'(COLS);
  localparam logic [5:0] CELLS_LIM = 6'(ROWS * COLS);
  localparam logic [2:0] BOTTOM    = 3'(ROWS - 1);

  state_t                           r_state;
  logic [2:0]                       r_col;
  cell_t                            r_player;
  logic [0:ROWS-1][0:COLS-1][1:0]   r_board;
  logic                             r_check_en;
  logic                             r_move_done;
  logic                             r_move_err;
  err_t                             r_err;
  logic                             r_game_over;
  logic [1:0]                       r_winner;
  logic                             r_draw;
  logic [5:0]                       r_move_count;

  logic [COLS-1:0][2:0]             w_heights;
  logic [COLS-1:0]                  w_col_full;
  logic                             w_inc_en;
  logic [2:0]                       w_row;

  // A clear in the same cycle as WRITE cancels the increment.
  assign w_inc_en = (r_state == S_WRITE) && !clear_req;
  // Landing row: the lowest empty row of the latched column.
  assign w_row    = BOTTOM - w_heights[r_col];

  col_height_counter #(.ROWS(ROWS), .COLS(COLS)) u_heights (
    .clk      (clk),
    .rst      (rst),
    .inc_en   (w_inc_en),
    .inc_col  (r_col),
    .clr      (clear_req),
    .heights  (w_heights),
    .col_full (w_col_full)
  );

  // Move FSM with board array and game status; clear overrides every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_player     <= EMPTY;
      r_board      <= '0;
      r_check_en   <= 1'b0;
      r_move_done  <= 1'b0;
      r_move_err   <= 1'b0;
      r_err        <= ERR_NONE;
      r_game_over  <= 1'b0;
      r_winner     <= 2'b00;
      r_draw       <= 1'b0;
      r_move_count <= '0;
    end else begin
      r_check_en  <= 1'b0;
      r_move_done <= 1'b0;
      r_move_err  <= 1'b0;
      if (clear_req) begin
        r_state      <= S_CLEAR;
        r_board      <= '0;
        r_game_over  <= 1'b0;
        r_winner     <= 2'b00;
        r_draw       <= 1'b0;
        r_move_count <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (move_valid) begin
              if (r_game_over || !((move_player == P1) || (move_player == P2))) begin
                r_move_err <= 1'b1;
                r_err      <= ERR_STATE;
              end else if ({1'b0, move_col} >= COLS_LIM) begin
                r_move_err <= 1'b1;
                r_err      <= ERR_COL;
              end else if (w_col_full[move_col]) begin
                r_move_err <= 1'b1;
                r_err      <= ERR_FULL;
              end else begin
                r_col    <= move_col;
                r_player <= cell_t'(move_player);
                r_state  <= S_WRITE;
              end
            end
          end
          S_WRITE: begin
            r_board[w_row][r_col] <= r_player;
            if (r_move_count != CELLS_LIM) begin
              r_move_count <= r_move_count + 6'd1;
            end
            r_check_en <= 1'b1;
            r_state    <= S_CHECK;
          end
          S_CHECK: begin
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (win_flag) begin
              r_game_over <= 1'b1;
              r_winner    <= winner_id;
            end else if (r_move_count == CELLS_LIM) begin
              r_game_over <= 1'b1;
              r_draw      <= 1'b1;
              r_winner    <= 2'b00;
            end
            r_move_done <= 1'b1;
            r_state     <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign board      = r_board;
  assign check_en   = r_check_en;
  assign move_ready = (r_state == S_IDLE);
  assign move_done  = r_move_done;
  assign move_err   = r_move_err;
  assign err_code   = r_err;
  assign game_over  = r_game_over;
  assign winner     = r_winner;
  assign draw       = r_draw;
  assign col_full   = w_col_full;
  assign move_count = r_move_count;

endmodule

// File: tb/tb_board_writer.sv
// Bench for board_writer: a plain Connect-4 game model (array board, column
// heights, four-in-a-row search) predicts every outcome of each drop.
module tb_board_writer;

  localparam int R = 6;
  localparam int C = 7;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic                        move_valid = 1'b0;
  logic [2:0]                  move_col = '0;
  logic [1:0]                  move_player = '0;
  logic                        clear_req = 1'b0;
  logic                        win_flag = 1'b0;
  logic [1:0]                  winner_id = '0;
  logic [0:R-1][0:C-1][1:0]    board;
  logic                        check_en, move_ready, move_done, move_err;
  logic [1:0]                  err_code;
  logic                        game_over;
  logic [1:0]                  winner;
  logic                        draw;
  logic [C-1:0]                col_full;
  logic [5:0]                  move_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference game state
  logic [1:0] m_b [R][C];
  int         m_h [C];
  int         m_cnt;
  bit         m_over;
  bit         m_draw;
  logic [1:0] m_win;
  bit         force_nowin;

  board_writer dut (
    .clk(clk), .rst(rst), .move_valid(move_valid), .move_col(move_col),
    .move_player(move_player), .clear_req(clear_req), .win_flag(win_flag),
    .winner_id(winner_id), .board(board), .check_en(check_en),
    .move_ready(move_ready), .move_done(move_done), .move_err(move_err),
    .err_code(err_code), .game_over(game_over), .winner(winner), .draw(draw),
    .col_full(col_full), .move_count(move_count)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) m_b[r][c] = 2'b00;
    for (int c = 0; c < C; c++) m_h[c] = 0;
    m_cnt = 0; m_over = 0; m_draw = 0; m_win = 2'b00;
  endfunction

  // Any four-in-a-row of piece p, in any of the four directions.
  function automatic bit model_win(input logic [1:0] p);
    int dr [4] = '{0, 1, 1, 1};
    int dc [4] = '{1, 0, 1, -1};
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        for (int d = 0; d < 4; d++) begin
          int k;
          for (k = 0; k < 4; k++) begin
            int rr = r + k * dr[d];
            int cc = c + k * dc[d];
            if (rr < 0 || rr >= R || cc < 0 || cc >= C) break;
            if (m_b[rr][cc] != p) break;
          end
          if (k == 4) return 1'b1;
        end
    return 1'b0;
  endfunction

  function automatic int board_diffs();
    int n = 0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        if (board[r][c] !== m_b[r][c]) n++;
    return n;
  endfunction

  function automatic logic [C-1:0] model_full();
    logic [C-1:0] f = '0;
    for (int c = 0; c < C; c++) f[c] = (m_h[c] == R);
    return f;
  endfunction

  // One drop request, checked cycle by cycle against the model.
  task automatic drive_move(input int col, input int pl);
    int         exp_err;
    int         n;
    logic [1:0] p;
    bit         w;
    p = pl[1:0];
    exp_err = 0;
    if (m_over || !(pl == 1 || pl == 2)) exp_err = 3;
    else if (col >= C) exp_err = 1;
    else if (m_h[col] == R) exp_err = 2;
    @(negedge clk);
    move_valid = 1'b1; move_col = col[2:0]; move_player = p;
    @(posedge clk); #1;
    if (exp_err != 0) begin
      vectors++;
      if (move_err !== 1'b1 || err_code !== exp_err[1:0]) begin
        miscompares++;
        $display("FAIL reject col=%0d pl=%0d: move_err=%b err_code=%b, want 1/%0d", col, pl, move_err, err_code, exp_err);
      end
      move_valid = 1'b0;
      n = board_diffs();
      vectors++;
      if (n != 0 || move_count !== 6'(m_cnt) || move_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL reject_untouched: %0d cells differ, move_count=%0d want %0d, ready=%b", n, move_count, m_cnt, move_ready);
      end
    end else begin
      vectors++;
      if (move_ready !== 1'b0 || move_err !== 1'b0) begin
        miscompares++;
        $display("FAIL accept col=%0d: move_ready=%b move_err=%b, want 0/0", col, move_ready, move_err);
      end
      m_b[R - 1 - m_h[col]][col] = p;
      m_h[col]++;
      m_cnt++;
      w = !force_nowin && model_win(p);
      @(posedge clk); #1;
      n = board_diffs();
      vectors++;
      if (check_en !== 1'b1 || n != 0 || col_full !== model_full()) begin
        miscompares++;
        $display("FAIL check_phase col=%0d: check_en=%b want 1, %0d cells differ, col_full=%b want %b", col, check_en, n, col_full, model_full());
      end
      win_flag = w; winner_id = w ? p : 2'b00;
      @(posedge clk); #1;
      vectors++;
      if (check_en !== 1'b0 || move_done !== 1'b0 || move_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL wait_phase: check_en=%b move_done=%b ready=%b, want 0/0/0", check_en, move_done, move_ready);
      end
      if (w) begin m_over = 1; m_win = p; end
      else if (m_cnt == R * C) begin m_over = 1; m_draw = 1; m_win = 2'b00; end
      @(posedge clk); #1;
      vectors++;
      if (move_done !== 1'b1 || move_ready !== 1'b1 || game_over !== m_over || winner !== m_win ||
          draw !== m_draw || move_count !== 6'(m_cnt)) begin
        miscompares++;
        $display("FAIL done col=%0d: done=%b ready=%b over=%b win=%b draw=%b cnt=%0d, want 1/1/%b/%b/%b/%0d",
                 col, move_done, move_ready, game_over, winner, draw, move_count, m_over, m_win, m_draw, m_cnt);
      end
      move_valid = 1'b0; win_flag = 1'b0; winner_id = 2'b00;
      @(posedge clk); #1;
      vectors++;
      if (move_done !== 1'b0) begin
        miscompares++;
        $display("FAIL done_pulse: move_done=%b after one cycle, want 0", move_done);
      end
    end
  endtask

  task automatic do_clear();
    @(negedge clk); clear_req = 1'b1;
    @(posedge clk); #1;
    model_reset();
    vectors++;
    if (board_diffs() != 0 || move_count !== 6'd0 || game_over !== 1'b0 || draw !== 1'b0 ||
        winner !== 2'b00 || move_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL clear: cnt=%0d over=%b draw=%b win=%b ready=%b, want 0/0/0/00/0", move_count, game_over, draw, winner, move_ready);
    end
    clear_req = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (move_ready !== 1'b1 || col_full !== '0) begin
      miscompares++;
      $display("FAIL clear_exit: ready=%b col_full=%b, want 1/0", move_ready, col_full);
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b0;
    #12;
    vectors++;
    if (board_diffs() != 0 || move_count !== 6'd0 || check_en !== 1'b0 || move_done !== 1'b0 ||
        move_err !== 1'b0 || game_over !== 1'b0 || draw !== 1'b0 || winner !== 2'b00 ||
        err_code !== 2'b00 || move_ready !== 1'b1 || col_full !== '0) begin
      miscompares++;
      $display("FAIL reset: cnt=%0d chk=%b done=%b err=%b over=%b draw=%b win=%b code=%b ready=%b",
               move_count, check_en, move_done, move_err, game_over, draw, winner, err_code, move_ready);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_first_drop();
    drive_move(3, 1);
  endtask

  task automatic test_column_fill();
    do_clear();
    for (int i = 0; i < R; i++) drive_move(0, (i % 2) + 1);
    drive_move(0, 1);
  endtask

  task automatic test_bad_inputs();
    do_clear();
    drive_move(7, 1);
    drive_move(2, 0);
    drive_move(2, 3);
  endtask

  task automatic test_win();
    do_clear();
    for (int c = 0; c < 4; c++) drive_move(c, 1);
    drive_move(5, 2);
  endtask

  task automatic test_draw();
    do_clear();
    force_nowin = 1;
    for (int c = 0; c < C; c++)
      for (int r = 0; r < R; r++) drive_move(c, ((c + r) % 2) + 1);
    drive_move(0, 1);
    force_nowin = 0;
  endtask

  task automatic test_clear_in_flight();
    do_clear();
    drive_move(4, 2);
    @(negedge clk);
    move_valid = 1'b1; move_col = 3'd1; move_player = 2'b01;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++;
    if (check_en !== 1'b1) begin
      miscompares++;
      $display("FAIL inflight_check: check_en=%b, want 1", check_en);
    end
    clear_req = 1'b1;
    @(posedge clk); #1;
    model_reset();
    vectors++;
    if (board_diffs() != 0 || move_count !== 6'd0 || game_over !== 1'b0 || move_done !== 1'b0) begin
      miscompares++;
      $display("FAIL inflight_clear: cnt=%0d over=%b done=%b, want 0/0/0", move_count, game_over, move_done);
    end
    clear_req = 1'b0; move_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (move_done !== 1'b0 || move_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL inflight_nodone: done=%b ready=%b, want 0/1", move_done, move_ready);
    end
  endtask

  task automatic test_async_reset();
    drive_move(2, 1);
    drive_move(2, 2);
    @(negedge clk);
    move_valid = 1'b1; move_col = 3'd5; move_player = 2'b01;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (board_diffs() != 0 || move_count !== 6'd0 || move_ready !== 1'b1 || col_full !== '0 ||
        check_en !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: cnt=%0d ready=%b col_full=%b chk=%b, want 0/1/0/0", move_count, move_ready, col_full, check_en);
    end
    move_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    drive_move(5, 2);
  endtask

  task automatic test_random_games();
    int pl_turn = 1;
    for (int i = 0; i < 160; i++) begin
      int col = $urandom_range(0, 7);
      int pl  = pl_turn;
      if ($urandom_range(0, 9) == 0) pl = ($urandom_range(0, 1) == 0) ? 0 : 3;
      drive_move(col, pl);
      if (pl == pl_turn) pl_turn = 3 - pl_turn;
      if (m_over && $urandom_range(0, 2) == 0) do_clear();
    end
  endtask

  initial begin
    force_nowin = 0;
    model_reset();
    test_reset();
    test_first_drop();
    test_column_fill();
    test_bad_inputs();
    test_win();
    test_draw();
    test_clear_in_flight();
    test_async_reset();
    do_clear();
    test_random_games();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
